// File: rtl/freq_sweep_opt_if.sv
// Signal bundle between a sweep controller and the frequency-sweep optimiser.
// The master side drives the request, the bounds and the current sample; the slave side reports results.
interface freq_sweep_opt_if #(
   parameter int FREQ_W = 20,
   parameter int ADC_W  = 12
);
   logic              alive;
   logic              start;
   logic [FREQ_W-1:0] freq_lo;
   logic [FREQ_W-1:0] freq_hi;
   logic [FREQ_W-1:0] freq_step;
   logic [ADC_W-1:0]  adc;
   logic [FREQ_W-1:0] freq_out;
   logic [FREQ_W-1:0] best_freq;
   logic [ADC_W-1:0]  best_mean;
   logic              busy;
   logic              done;

   modport master (
      output alive, start, freq_lo, freq_hi, freq_step, adc,
      input  freq_out, best_freq, best_mean, busy, done
   );

   modport slave (
      input  alive, start, freq_lo, freq_hi, freq_step, adc,
      output freq_out, best_freq, best_mean, busy, done
   );
endinterface

// File: rtl/freq_sweep_opt.sv
// Steps the SWIPT output frequency from freq_lo towards freq_hi, averages the sensed
// current at each point and parks the output on the best-scoring frequency.
module freq_sweep_opt #(
   parameter int                FREQ_W     = 20,
   parameter int                ADC_W      = 12,
   parameter int                AVG_LOG2   = 4,
   parameter int                SETTLE_CYC = 1000,
   parameter int                MAXIMIZE   = 1,
   parameter logic [FREQ_W-1:0] F_DEFAULT  = 20'h88B8
) (
   input  logic clk,
   input  logic nrst,
   freq_sweep_opt_if.slave bus
);
   localparam int          AVG_LEN     = 1 << AVG_LOG2;
   localparam int          ACC_W       = ADC_W + AVG_LOG2;
   localparam logic [31:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 32'd0 : 32'(SETTLE_CYC - 1);
   localparam logic [31:0] ACC_LAST    = 32'(AVG_LEN - 1);

   typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, COMPARE, FINISH} state_t;

   state_t            state_reg, state_next;
   logic [FREQ_W-1:0] hi_reg, step_reg;
   logic [FREQ_W-1:0] freq_out_reg, best_freq_reg, run_freq_reg;
   logic [ADC_W-1:0]  best_mean_reg, run_mean_reg;
   logic              first_reg;
   logic [31:0]       cnt_reg;
   logic [ACC_W-1:0]  acc_reg;

   logic              abort, settle_done, accum_done, better, take_point, last_point;
   logic [ADC_W-1:0]  mean;
   logic [FREQ_W-1:0] cand_freq;
   logic [ADC_W-1:0]  cand_mean;
   logic [FREQ_W:0]   freq_sum;

   always_comb begin
      abort       = (state_reg != IDLE) && !bus.alive;
      settle_done = (cnt_reg == SETTLE_LAST);
      accum_done  = (cnt_reg == ACC_LAST);
      mean        = ADC_W'(acc_reg >> AVG_LOG2);
      better      = (MAXIMIZE != 0) ? (mean > run_mean_reg) : (mean < run_mean_reg);
      // Strict comparison: a tie keeps the earlier, lower frequency.
      take_point  = first_reg || better;
      cand_freq   = take_point ? freq_out_reg : run_freq_reg;
      cand_mean   = take_point ? mean : run_mean_reg;
      // One extra bit so a step past the top of the frequency range is caught, not wrapped.
      freq_sum    = {1'b0, freq_out_reg} + {1'b0, step_reg};
      last_point  = (step_reg == '0) || freq_sum[FREQ_W] || (freq_sum[FREQ_W-1:0] > hi_reg);
   end

   always_comb begin
      state_next = state_reg;
      if (abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (bus.start && bus.alive) state_next = SETTLE;
            SETTLE:  if (settle_done) state_next = ACCUM;
            ACCUM:   if (accum_done) state_next = COMPARE;
            COMPARE: state_next = last_point ? FINISH : SETTLE;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         hi_reg        <= '0;
         step_reg      <= '0;
         freq_out_reg  <= F_DEFAULT;
         best_freq_reg <= F_DEFAULT;
         best_mean_reg <= '0;
         run_freq_reg  <= '0;
         run_mean_reg  <= '0;
         first_reg     <= 1'b0;
         cnt_reg       <= '0;
         acc_reg       <= '0;
      end else if (abort) begin
         freq_out_reg <= F_DEFAULT;
         cnt_reg      <= '0;
         acc_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.start && bus.alive) begin
                  hi_reg       <= bus.freq_hi;
                  step_reg     <= bus.freq_step;
                  freq_out_reg <= bus.freq_lo;
                  first_reg    <= 1'b1;
                  cnt_reg      <= '0;
                  acc_reg      <= '0;
               end
            end
            SETTLE: cnt_reg <= settle_done ? 32'd0 : cnt_reg + 32'd1;
            ACCUM: begin
               acc_reg <= acc_reg + ACC_W'(bus.adc);
               cnt_reg <= accum_done ? 32'd0 : cnt_reg + 32'd1;
            end
            COMPARE: begin
               run_freq_reg <= cand_freq;
               run_mean_reg <= cand_mean;
               first_reg    <= 1'b0;
               acc_reg      <= '0;
               // Results are published on entry to FINISH so they are valid alongside done.
               if (last_point) begin
                  freq_out_reg  <= cand_freq;
                  best_freq_reg <= cand_freq;
                  best_mean_reg <= cand_mean;
               end else begin
                  freq_out_reg <= freq_sum[FREQ_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.freq_out  = freq_out_reg;
   assign bus.best_freq = best_freq_reg;
   assign bus.best_mean = best_mean_reg;
   assign bus.busy      = (state_reg != IDLE);
   assign bus.done      = (state_reg == FINISH);
endmodule

// File: doc/freq_sweep_opt.md
FREQ_SWEEP_OPT -- requirements
Module: freq_sweep_opt

Interface
REQ-001 Parameter FREQ_W, 20, width of frequency words (Hz).
REQ-002 Parameter ADC_W, 12, width of ADC samples.
REQ-003 Parameter AVG_LOG2, 4, log2 of samples averaged per sweep point (AVG_LEN = 2^AVG_LOG2).
REQ-004 Parameter SETTLE_CYC, 1000, clk cycles waited after each frequency change before sampling.
REQ-005 Parameter MAXIMIZE, 1, 1 = select frequency with highest mean, 0 = lowest mean.
REQ-006 Parameter F_DEFAULT, 20'h88B8, frequency driven when idle or after reset (35 kHz).
REQ-007 clk  in  1  system clock, all logic on rising edge.
REQ-008 nrst  in  1  reset, synchronous, active-low.
REQ-009 alive  in  1  SWIPT link alive; low aborts any sweep.
REQ-010 start  in  1  single-cycle sweep request, sampled only in IDLE.
REQ-011 freq_lo  in  FREQ_W  first sweep frequency, latched on accepted start.
REQ-012 freq_hi  in  FREQ_W  last allowed sweep frequency, latched on accepted start.
REQ-013 freq_step  in  FREQ_W  increment between points, latched on accepted start.
REQ-014 adc  in  ADC_W  current-sense sample, valid every cycle.
REQ-015 freq_out  out  FREQ_W  frequency commanded to the SWIPT output stage.
REQ-016 best_freq  out  FREQ_W  winning frequency of last completed sweep.
REQ-017 best_mean  out  ADC_W  mean current at best_freq.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 done  out  1  one-cycle pulse on sweep completion.

Function
REQ-020 FSM states SHALL be IDLE, SETTLE, ACCUM, COMPARE, FINISH.
REQ-021 IDLE: on start=1 and alive=1, latch bounds, set freq_out=freq_lo, clear settle counter, go SETTLE next cycle.
REQ-022 start SHALL be ignored when busy=1 or alive=0.
REQ-023 SETTLE: count SETTLE_CYC cycles at constant freq_out, then go ACCUM; SETTLE_CYC=0 SHALL go to ACCUM after one cycle.
REQ-024 ACCUM: add adc to an accumulator of width ADC_W+AVG_LOG2 (no overflow possible) for exactly AVG_LEN consecutive cycles, then go COMPARE.
REQ-025 COMPARE (one cycle): mean = accumulator >> AVG_LOG2 (truncating); on first point of a sweep, or if mean strictly better per MAXIMIZE, update internal best freq/mean; ties keep the earlier (lower) frequency.
REQ-026 COMPARE: next = freq_out + freq_step computed in FREQ_W+1 bits; if freq_step=0, or next > freq_hi, or next bit FREQ_W set (wrap), go FINISH; else freq_out=next, accumulator cleared, go SETTLE.
REQ-027 freq_lo > freq_hi SHALL measure exactly one point at freq_lo.
REQ-028 FINISH (one cycle): freq_out, best_freq, best_mean take the internal best values; done=1; return to IDLE next cycle.
REQ-029 best_freq/best_mean SHALL change only in FINISH and hold until the next FINISH.
REQ-030 In IDLE, freq_out SHALL hold best_freq after a completed sweep, F_DEFAULT otherwise.
REQ-031 alive=0 in any non-IDLE state SHALL go to IDLE next cycle, freq_out=F_DEFAULT, no done pulse, best_freq/best_mean unchanged.
REQ-032 Per-point latency SHALL be SETTLE_CYC + AVG_LEN + 1 cycles; total = points x that + 2 (start and FINISH cycles).

Reset
REQ-033 nrst=0 at a clock edge SHALL force IDLE, freq_out=F_DEFAULT, best_freq=F_DEFAULT, best_mean=0, busy=0, done=0, counters and accumulator 0, regardless of state; nrst has priority over alive and start.
REQ-034 After reset release, first sweep SHALL be accepted on the first cycle with start=1, alive=1.

Verification
REQ-035 freq_lo=30000, freq_hi=40000, step=2500, SETTLE_CYC=4, AVG_LOG2=2, adc model peaks at 35000 -> 5 points, freq_out 30000..40000, done after 5x9+2=47 cycles, best_freq=35000.
REQ-036 Equal adc=100 at all points -> best_freq=30000 (tie keeps first), best_mean=100.
REQ-037 freq_lo=0xFFF00, freq_hi=0xFFFFF, step=0x80 -> points 0xFFF00, 0xFFF80 only, wrap detected, FINISH with no freq_out wrap to low value.
REQ-038 step=0 or freq_lo=40000>freq_hi=30000 -> single point at freq_lo, best_freq=freq_lo.
REQ-039 alive dropped during ACCUM of point 3 -> IDLE next cycle, freq_out=35000 (F_DEFAULT), no done, prior best_freq retained; start during busy ignored.
REQ-040 nrst asserted mid-SETTLE -> all outputs at reset values next cycle; MAXIMIZE=0 run of REQ-035 with inverted model -> best_freq=35000.
